// File: rtl/alu_sequencer.sv
// Operand/result sequencer for the combinational ALU: latches operands, holds them for the
// opcode's DRIVE time, then captures the result into Z. Optional macro: ALU_SEQ_DIVZERO_CHECK_EN.
module alu_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULDIV_WAIT = 4
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    output logic               ready,
    input  logic [4:0]         opcode_in,
    input  logic [WIDTH-1:0]   ra_in,
    input  logic [WIDTH-1:0]   rb_in,
    output logic [4:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [2*WIDTH-1:0] alu_rc,
    output logic [WIDTH-1:0]   z_hi,
    output logic [WIDTH-1:0]   z_lo,
    output logic               done,
    output logic               illegal,
    output logic               div_zero
);

    localparam int CW = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;

    localparam logic [4:0] OP_DIV = 5'b01100;
    localparam logic [4:0] OP_MUL = 5'b01101;
    localparam logic [4:0] OP_NEG = 5'b01110;
    localparam logic [4:0] OP_NOT = 5'b01111;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d, b_q, b_d, zhi_q, zhi_d, zlo_q, zlo_d;
    logic [4:0]       op_q, op_d;
    logic             ill_q, ill_d;

    logic legal, muldiv, unary, accept, capture, dz_req;

    assign legal   = (opcode_in <= 5'd8) || (opcode_in[4:2] == 3'b011);
    assign muldiv  = (opcode_in == OP_DIV) || (opcode_in == OP_MUL);
    assign unary   = (opcode_in == OP_NEG) || (opcode_in == OP_NOT);
    assign accept  = (state_q == S_IDLE) && start;
    assign capture = (state_q == S_DRIVE) && (cnt_q == '0);

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    logic dzf_q, dzf_d;
    assign dz_req = (opcode_in == OP_DIV) && (rb_in == '0);
`else
    assign dz_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (legal && !dz_req) ? S_DRIVE : S_DONE;
            S_DRIVE: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; rejected requests leave Y/B/opcode/Z untouched
    always_comb begin
        y_d   = y_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        zhi_d = zhi_q;
        zlo_d = zlo_q;
        ill_d = ill_q;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        dzf_d = dzf_q;
`endif
        if (accept) begin
            ill_d = !legal;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            dzf_d = legal && dz_req;
`endif
            if (legal && !dz_req) begin
                y_d   = ra_in;
                b_d   = unary ? '0 : rb_in;
                op_d  = opcode_in;
                cnt_d = muldiv ? CW'(MULDIV_WAIT - 1) : '0;
            end
        end
        if ((state_q == S_DRIVE) && (cnt_q != '0)) cnt_d = cnt_q - CW'(1);
        if (capture) begin
            zhi_d = alu_rc[2*WIDTH-1:WIDTH];
            zlo_d = alu_rc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            y_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
            ill_q <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            dzf_q <= 1'b0;
`endif
        end else begin
            y_q   <= y_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
            zhi_q <= zhi_d;
            zlo_q <= zlo_d;
            ill_q <= ill_d;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            dzf_q <= dzf_d;
`endif
        end
    end

    // Outputs; status flags only show while done is high
    always_comb begin
        ready   = (state_q == S_IDLE);
        done    = (state_q == S_DONE);
        illegal = done && ill_q;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        div_zero = done && dzf_q;
`else
        div_zero = 1'b0;
`endif
    end

    assign alu_opcode = op_q;
    assign alu_a      = y_q;
    assign alu_b      = b_q;
    assign z_hi       = zhi_q;
    assign z_lo       = zlo_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU stand-in, directed scenarios and a
// randomized back-to-back run checked against a transaction-level model.
module tb_alu_sequencer;

    localparam int W  = 32;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          clear_n;
    logic          start;
    logic          ready;
    logic [4:0]    opcode_in;
    logic [W-1:0]  ra_in, rb_in;
    logic [4:0]    alu_opcode;
    logic [W-1:0]  alu_a, alu_b;
    logic [2*W-1:0] alu_rc;
    logic [W-1:0]  z_hi, z_lo;
    logic          done, illegal, div_zero;

    int n_cmp = 0;
    int n_err = 0;

    // model state: what Z should currently hold
    logic [W-1:0] mzh, mzl;

    // results of the last do_op
    int           r_lat, r_drv;
    bit           r_stab, r_rok, r_tok;
    logic [W-1:0] r_a0, r_b0, r_zh, r_zl;
    logic [4:0]   r_o0;
    logic         r_ill, r_dz;

    always #5 clock = ~clock;

    alu_sequencer #(.WIDTH(W), .MULDIV_WAIT(MW)) dut (
        .clock(clock), .clear_n(clear_n), .start(start), .ready(ready),
        .opcode_in(opcode_in), .ra_in(ra_in), .rb_in(rb_in),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_rc(alu_rc),
        .z_hi(z_hi), .z_lo(z_lo), .done(done), .illegal(illegal), .div_zero(div_zero)
    );

    function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  s;
        s = b[4:0];
        r = 32'h0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a >> s;
            5'd5:  r = $signed(a) >>> s;
            5'd6:  r = a << s;
            5'd7:  r = (a >> s) | (a << (6'd32 - {1'b0, s}));
            5'd8:  r = (a << s) | (a >> (6'd32 - {1'b0, s}));
            5'd12: return (b == 32'h0) ? 64'hDEAD_BEEF_0BAD_0BAD : {a % b, a / b};
            5'd13: return {32'h0, a} * {32'h0, b};
            5'd14: r = -a;
            5'd15: r = ~a;
            default: r = 32'h0BAD_C0DE;
        endcase
        return {32'h0, r};
    endfunction

    assign alu_rc = alu_f(alu_opcode, alu_a, alu_b);

    function automatic bit is_legal(input logic [4:0] op);
        return (op <= 5'd8) || (op >= 5'd12 && op <= 5'd15);
    endfunction

    // Issue one request at a negedge with ready high; returns at the negedge after done.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        r_rok = ready;
        start = 1'b1; opcode_in = op; ra_in = a; rb_in = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        r_lat = -1; r_drv = 0; r_stab = 1'b1; r_ill = 1'b0; r_dz = 1'b0;
        r_a0 = '0; r_b0 = '0; r_o0 = '0; r_zh = '0; r_zl = '0;
        for (int i = 1; i <= 40; i++) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1)); opcode_in = 5'($urandom);
                ra_in = $urandom; rb_in = $urandom;
            end
            if (done) begin
                r_lat = i; r_ill = illegal; r_dz = div_zero; r_zh = z_hi; r_zl = z_lo;
                break;
            end
            if (!ready) begin
                if (r_drv == 0) begin
                    r_a0 = alu_a; r_b0 = alu_b; r_o0 = alu_opcode;
                end else if (alu_a !== r_a0 || alu_b !== r_b0 || alu_opcode !== r_o0) begin
                    r_stab = 1'b0;
                end
                r_drv++;
            end
            @(negedge clock);
        end
        @(negedge clock);
        start = 1'b0;
        r_tok = ready && !done && !illegal && !div_zero;
    endtask

    task automatic test_reset;
        clear_n = 1'b0; start = 1'b0; opcode_in = '0; ra_in = '0; rb_in = '0;
        #3;
        n_cmp++;
        if ({ready, done, illegal, div_zero} !== 4'b1000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 1000", {ready, done, illegal, div_zero});
        end
        n_cmp++;
        if ({z_hi, z_lo, alu_a, alu_b, alu_opcode} !== '0) begin
            n_err++; $display("FAIL reset_regs: got z=%h_%h a=%h b=%h op=%h want all 0", z_hi, z_lo, alu_a, alu_b, alu_opcode);
        end
        @(negedge clock); @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        mzh = '0; mzl = '0;
    endtask

    task automatic test_add;
        do_op(5'd0, 32'd5, 32'd7, 1'b0);
        mzh = 32'h0; mzl = 32'd12;
        n_cmp++; if (r_rok !== 1'b1) begin n_err++; $display("FAIL add_ready: got %b want 1", r_rok); end
        n_cmp++; if (r_lat !== 2) begin n_err++; $display("FAIL add_latency: got %0d want 2", r_lat); end
        n_cmp++; if (r_drv !== 1) begin n_err++; $display("FAIL add_drive: got %0d want 1", r_drv); end
        n_cmp++; if ({r_a0, r_b0} !== {32'd5, 32'd7} || !r_stab) begin
            n_err++; $display("FAIL add_operands: got a=%h b=%h stable=%b want 5 7 1", r_a0, r_b0, r_stab); end
        n_cmp++; if ({r_zh, r_zl} !== {mzh, mzl}) begin
            n_err++; $display("FAIL add_z: got %h_%h want %h_%h", r_zh, r_zl, mzh, mzl); end
        n_cmp++; if (r_tok !== 1'b1) begin n_err++; $display("FAIL add_done_pulse: got %b want 1", r_tok); end
    endtask

    task automatic test_illegal;
        do_op(5'b10101, $urandom, $urandom, 1'b0);
        n_cmp++; if (r_lat !== 1 || r_drv !== 0) begin
            n_err++; $display("FAIL ill_latency: got lat=%0d drv=%0d want 1 0", r_lat, r_drv); end
        n_cmp++; if ({r_ill, r_dz} !== 2'b10) begin n_err++; $display("FAIL ill_flags: got %b want 10", {r_ill, r_dz}); end
        n_cmp++; if ({r_zh, r_zl} !== {mzh, mzl}) begin
            n_err++; $display("FAIL ill_z_kept: got %h_%h want %h_%h", r_zh, r_zl, mzh, mzl); end
        n_cmp++; if ({alu_a, alu_b, alu_opcode} !== {32'd5, 32'd7, 5'd0}) begin
            n_err++; $display("FAIL ill_regs_kept: got a=%h b=%h op=%h want 5 7 0", alu_a, alu_b, alu_opcode); end
        n_cmp++; if (r_tok !== 1'b1) begin n_err++; $display("FAIL ill_done_pulse: got %b want 1", r_tok); end
    endtask

    task automatic test_mul;
        do_op(5'd13, 32'h0001_0000, 32'h0001_0000, 1'b0);
        mzh = 32'h1; mzl = 32'h0;
        n_cmp++; if (r_lat !== MW + 1 || r_drv !== MW) begin
            n_err++; $display("FAIL mul_timing: got lat=%0d drv=%0d want %0d %0d", r_lat, r_drv, MW + 1, MW); end
        n_cmp++; if (!r_stab || r_o0 !== 5'd13) begin
            n_err++; $display("FAIL mul_stable: got stable=%b op=%h want 1 0d", r_stab, r_o0); end
        n_cmp++; if ({r_zh, r_zl} !== {mzh, mzl}) begin
            n_err++; $display("FAIL mul_z: got %h_%h want %h_%h", r_zh, r_zl, mzh, mzl); end
    endtask

    task automatic test_not_noise;
        do_op(5'd15, 32'h0, 32'hFFFF_FFFF, 1'b1);
        mzh = 32'h0; mzl = 32'hFFFF_FFFF;
        n_cmp++; if (r_b0 !== 32'h0 || !r_stab) begin
            n_err++; $display("FAIL not_b_zero: got b=%h stable=%b want 0 1", r_b0, r_stab); end
        n_cmp++; if (r_lat !== 2 || r_drv !== 1) begin
            n_err++; $display("FAIL not_timing: got lat=%0d drv=%0d want 2 1", r_lat, r_drv); end
        n_cmp++; if ({r_zh, r_zl} !== {mzh, mzl}) begin
            n_err++; $display("FAIL not_z: got %h_%h want %h_%h", r_zh, r_zl, mzh, mzl); end
        n_cmp++; if (r_tok !== 1'b1) begin n_err++; $display("FAIL not_start_ignored: got %b want 1", r_tok); end
    endtask

    task automatic test_reset_mid_div;
        int dcnt;
        start = 1'b1; opcode_in = 5'd12; ra_in = 32'd100; rb_in = 32'd7;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        clear_n = 1'b0;
        #1;
        mzh = '0; mzl = '0;
        n_cmp++; if ({ready, done, z_hi, z_lo} !== {2'b10, 64'h0}) begin
            n_err++; $display("FAIL rst_mid: got ready=%b done=%b z=%h_%h want 1 0 0_0", ready, done, z_hi, z_lo); end
        @(negedge clock);
        clear_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || !ready) dcnt++;
            @(negedge clock);
        end
        n_cmp++; if (dcnt !== 0) begin n_err++; $display("FAIL rst_no_done: got %0d busy cycles want 0", dcnt); end
        do_op(5'd0, 32'd3, 32'd4, 1'b0);
        mzl = 32'd7;
        n_cmp++; if (r_lat !== 2 || {r_zh, r_zl} !== {mzh, mzl}) begin
            n_err++; $display("FAIL rst_then_add: got lat=%0d z=%h_%h want 2 %h_%h", r_lat, r_zh, r_zl, mzh, mzl); end
    endtask

    task automatic test_div_zero;
        do_op(5'd12, 32'd100, 32'd0, 1'b0);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        n_cmp++; if (r_lat !== 1 || r_drv !== 0 || r_dz !== 1'b1) begin
            n_err++; $display("FAIL divz: got lat=%0d drv=%0d dz=%b want 1 0 1", r_lat, r_drv, r_dz); end
`else
        {mzh, mzl} = alu_f(5'd12, 32'd100, 32'd0);
        n_cmp++; if (r_lat !== MW + 1 || r_drv !== MW || r_dz !== 1'b0) begin
            n_err++; $display("FAIL divz: got lat=%0d drv=%0d dz=%b want %0d %0d 0", r_lat, r_drv, r_dz, MW + 1, MW); end
`endif
        n_cmp++; if ({r_zh, r_zl} !== {mzh, mzl} || r_ill !== 1'b0) begin
            n_err++; $display("FAIL divz_z: got z=%h_%h ill=%b want %h_%h 0", r_zh, r_zl, r_ill, mzh, mzl); end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  op;
        logic [31:0] a, b, eb;
        bit          lg, dzc;
        int          wt;
        for (int k = 0; k < 60; k++) begin
            op = 5'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            lg = is_legal(op);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            dzc = lg && op == 5'd12 && b == 32'h0;
`else
            dzc = 1'b0;
`endif
            eb = (op == 5'd14 || op == 5'd15) ? 32'h0 : b;
            wt = (!lg || dzc) ? 0 : ((op == 5'd12 || op == 5'd13) ? MW : 1);
            if (lg && !dzc) {mzh, mzl} = alu_f(op, a, eb);
            do_op(op, a, b, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (r_rok !== 1'b1 || r_lat !== wt + 1 || r_drv !== wt || r_tok !== 1'b1) begin
                n_err++; $display("FAIL b2b_timing[%0d] op=%h: got rdy=%b lat=%0d drv=%0d tail=%b want 1 %0d %0d 1",
                                  k, op, r_rok, r_lat, r_drv, r_tok, wt + 1, wt);
            end
            n_cmp++;
            if ({r_ill, r_dz} !== {!lg, dzc} || {r_zh, r_zl} !== {mzh, mzl}) begin
                n_err++; $display("FAIL b2b_result[%0d] op=%h: got ill=%b dz=%b z=%h_%h want %b %b %h_%h",
                                  k, op, r_ill, r_dz, r_zh, r_zl, !lg, dzc, mzh, mzl);
            end
            if (wt > 0) begin
                n_cmp++;
                if ({r_a0, r_b0, r_o0} !== {a, eb, op} || !r_stab) begin
                    n_err++; $display("FAIL b2b_drive[%0d]: got a=%h b=%h op=%h stable=%b want %h %h %h 1",
                                      k, r_a0, r_b0, r_o0, r_stab, a, eb, op);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_add;
        test_illegal;
        test_mul;
        test_not_noise;
        test_reset_mid_div;
        test_div_zero;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
